// File: rtl/mux_3x3_pkg.sv
// Shared constants for the 3-channel selector: select encodings and default data width.
package mux_3x3_pkg;

    // Default data width of every channel and result.
    localparam int unsigned DEFAULT_WIDTH = 3;

    // Channel select encodings.
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_INV = 2'b11;

    // True when the select code names no channel.
    function automatic logic sel_is_invalid(input logic [1:0] sel);
        return (sel == SEL_INV);
    endfunction

endpackage

// File: rtl/mux_3x3_if.sv
// Bundle of the selector's data/select inputs and its combinational and registered outputs.
interface mux_3x3_if
    import mux_3x3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] entrada0;
    logic [WIDTH-1:0] entrada1;
    logic [WIDTH-1:0] entrada2;
    logic [1:0]       controle;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] resultado_reg;
    logic             invalido;
    logic             erro_sticky;

    // Driver side: supplies channels and select, observes results.
    modport master (
        output entrada0,
        output entrada1,
        output entrada2,
        output controle,
        input  resultado,
        input  resultado_reg,
        input  invalido,
        input  erro_sticky
    );

    // Selector side.
    modport slave (
        input  entrada0,
        input  entrada1,
        input  entrada2,
        input  controle,
        output resultado,
        output resultado_reg,
        output invalido,
        output erro_sticky
    );

endinterface

// File: rtl/mux3_comb.sv
// Purely combinational 3:1 selector; the unused select code yields zero data and flags invalid.
module mux3_comb
    import mux_3x3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_entrada0,
    input  logic [WIDTH-1:0] i_entrada1,
    input  logic [WIDTH-1:0] i_entrada2,
    input  logic [1:0]       i_controle,
    output logic [WIDTH-1:0] o_resultado,
    output logic             o_invalido
);

    // Route the selected channel; an unknown select is left to propagate X in simulation.
    always_comb begin
        o_resultado = '0;
        case (i_controle)
            SEL_CH0: o_resultado = i_entrada0;
            SEL_CH1: o_resultado = i_entrada1;
            SEL_CH2: o_resultado = i_entrada2;
            SEL_INV: o_resultado = '0;
            default: o_resultado = {WIDTH{1'bx}};
        endcase
    end

    assign o_invalido = sel_is_invalid(i_controle);

endmodule

// File: rtl/mux_3x3.sv
// 3-channel selector with a registered copy of the result and a sticky invalid-select flag.
module mux_3x3
    import mux_3x3_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic      i_clock,
    input  logic      i_reset_n,
    mux_3x3_if.slave  io_bus
);

    logic [WIDTH-1:0] w_resultado;
    logic             w_invalido;
    logic [WIDTH-1:0] r_resultado_reg;
    logic             r_erro_sticky;

    mux3_comb #(
        .WIDTH (WIDTH)
    ) u_mux3_comb (
        .i_entrada0  (io_bus.entrada0),
        .i_entrada1  (io_bus.entrada1),
        .i_entrada2  (io_bus.entrada2),
        .i_controle  (io_bus.controle),
        .o_resultado (w_resultado),
        .o_invalido  (w_invalido)
    );

    // Capture the selected data every edge; reset clears it immediately.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_resultado_reg <= '0;
        end else begin
            r_resultado_reg <= w_resultado;
        end
    end

    // Remember any edge that saw the invalid select; only reset clears it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_erro_sticky <= 1'b0;
        end else if (w_invalido) begin
            r_erro_sticky <= 1'b1;
        end
    end

    assign io_bus.resultado     = w_resultado;
    assign io_bus.invalido      = w_invalido;
    assign io_bus.resultado_reg = r_resultado_reg;
    assign io_bus.erro_sticky   = r_erro_sticky;

endmodule

// File: tb/tb_mux_3x3.sv
// Directed bench for mux_3x3: stimulus pushes hand-computed expectations, a monitor pops and checks.
module tb_mux_3x3;

    typedef struct {
        string    name;
        logic [2:0] res;
        logic       inv;
        logic [2:0] rreg;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    mux_3x3_if #(.WIDTH(3)) bus ();

    mux_3x3 #(
        .WIDTH (3)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus)
    );

    // 20-unit clock, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic drive(input logic [1:0] c, input logic [2:0] e0, input logic [2:0] e1,
                         input logic [2:0] e2);
        bus.controle = c;
        bus.entrada0 = e0;
        bus.entrada1 = e1;
        bus.entrada2 = e2;
    endtask

    // Let inputs settle one unit, queue the expectation, then hold one more unit.
    task automatic expect_now(input string name, input logic [2:0] res, input logic inv,
                              input logic [2:0] rreg, input logic err);
        exp_t e;
        #1;
        e.name = name;
        e.res  = res;
        e.inv  = inv;
        e.rreg = rreg;
        e.err  = err;
        sb.push_back(e);
        n_pushed++;
        #1;
    endtask

    task automatic cmp(input string name, input string field, input logic [2:0] act,
                       input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got %b, expected %b at t=%0t", name, field, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against each expectation as it arrives.
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            n_popped++;
            cmp(e.name, "resultado", bus.resultado, e.res);
            cmp(e.name, "invalido", {2'b00, bus.invalido}, {2'b00, e.inv});
            cmp(e.name, "resultado_reg", bus.resultado_reg, e.rreg);
            cmp(e.name, "erro_sticky", {2'b00, bus.erro_sticky}, {2'b00, e.err});
        end
    end

    // Watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 3'b101, 3'b000, 3'b000);
        // Combinational path valid during reset; registers held at zero.
        expect_now("rst_comb", 3'b101, 1'b0, 3'b000, 1'b0);
        bus.controle = 2'b11;
        expect_now("rst_inv", 3'b000, 1'b1, 3'b000, 1'b0);
        @(posedge clk);
        expect_now("rst_edge_inv", 3'b000, 1'b1, 3'b000, 1'b0);

        // Release reset, first edge loads normally.
        @(negedge clk);
        bus.controle = 2'b00;
        rst_n = 1'b1;
        expect_now("post_rst_pre", 3'b101, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        expect_now("post_rst_load", 3'b101, 1'b0, 3'b101, 1'b0);

        // Select stepping, zero latency.
        @(negedge clk);
        drive(2'b00, 3'b111, 3'b010, 3'b000);
        expect_now("step_ch0", 3'b111, 1'b0, 3'b101, 1'b0);
        bus.controle = 2'b01;
        expect_now("step_ch1", 3'b010, 1'b0, 3'b101, 1'b0);
        bus.controle = 2'b10;
        expect_now("step_ch2", 3'b000, 1'b0, 3'b101, 1'b0);
        bus.controle = 2'b00;
        expect_now("step_ch0b", 3'b111, 1'b0, 3'b101, 1'b0);
        @(posedge clk);
        expect_now("step_reg", 3'b111, 1'b0, 3'b111, 1'b0);

        // Invalid select and sticky error.
        @(negedge clk);
        drive(2'b11, 3'b101, 3'b110, 3'b011);
        expect_now("inv_comb", 3'b000, 1'b1, 3'b111, 1'b0);
        @(posedge clk);
        expect_now("inv_sticky", 3'b000, 1'b1, 3'b000, 1'b1);
        @(negedge clk);
        bus.controle = 2'b00;
        expect_now("inv_back_ch0", 3'b101, 1'b0, 3'b000, 1'b1);
        @(posedge clk);
        expect_now("inv_hold", 3'b101, 1'b0, 3'b101, 1'b1);

        // Register latency vs combinational path.
        @(negedge clk);
        drive(2'b01, 3'b101, 3'b110, 3'b011);
        expect_now("lat_comb", 3'b110, 1'b0, 3'b101, 1'b1);
        @(posedge clk);
        expect_now("lat_load", 3'b110, 1'b0, 3'b110, 1'b1);
        @(negedge clk);
        bus.entrada1 = 3'b001;
        expect_now("lat_between", 3'b001, 1'b0, 3'b110, 1'b1);
        @(posedge clk);
        expect_now("lat_next", 3'b001, 1'b0, 3'b001, 1'b1);
        @(negedge clk);
        bus.entrada1 = 3'b110;
        @(posedge clk);
        expect_now("lat_reload", 3'b110, 1'b0, 3'b110, 1'b1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        expect_now("arst_now", 3'b110, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        expect_now("arst_edge1", 3'b110, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        expect_now("arst_edge2", 3'b110, 1'b0, 3'b000, 1'b0);

        // Release with channel 2 selected.
        @(negedge clk);
        drive(2'b10, 3'b101, 3'b110, 3'b100);
        rst_n = 1'b1;
        expect_now("rel_pre", 3'b100, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        expect_now("rel_load", 3'b100, 1'b0, 3'b100, 1'b0);

        // Drain scoreboard with a bound.
        for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
        n_checks++;
        if (n_popped != n_pushed) begin
            n_errors++;
            $display("FAIL drain: got %0d popped, expected %0d", n_popped, n_pushed);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_3x3.md
MUX_3X3 -- requirements
Module: mux_3x3

Interface
- REQ-001 Parameter WIDTH, default 3, data width of every data input and output; ports below assume the default.
- REQ-002 Clock  input  1  single clock; all registers update on the rising edge.
- REQ-003 Reset  input  1  asynchronous, active-low reset (Reset=0 resets immediately; release is synchronized to Clock by the integrator).
- REQ-004 Entrada0  input  WIDTH  data channel 0.
- REQ-005 Entrada1  input  WIDTH  data channel 1.
- REQ-006 Entrada2  input  WIDTH  data channel 2.
- REQ-007 Controle  input  2  channel select: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> invalid.
- REQ-008 Resultado  output  WIDTH  combinational selected data.
- REQ-009 ResultadoReg  output  WIDTH  Resultado registered once per Clock.
- REQ-010 Invalido  output  1  combinational, high while Controle==11.
- REQ-011 ErroSticky  output  1  registered; set on any clock edge with Controle==11; cleared only by reset.

Function
- REQ-012 Resultado SHALL equal Entrada0/1/2 for Controle 00/01/10, with zero clock latency, in the same delta as any input change.
- REQ-013 For Controle==11, Resultado SHALL be all zeros and Invalido SHALL be 1; otherwise Invalido SHALL be 0.
- REQ-014 Resultado and Invalido SHALL NOT depend on Clock or Reset; they SHALL be valid during reset.
- REQ-015 ResultadoReg SHALL load the current Resultado on every rising Clock edge while Reset=1 (one-cycle latency, no enable).
- REQ-016 ErroSticky SHALL go to 1 on the first rising edge sampling Controle==11 and SHALL stay 1 until Reset is asserted.
- REQ-017 Simultaneous change of Controle and data SHALL resolve to the new data on the new channel; no glitch filtering or hold is required.
- REQ-018 Unknown (X/Z) bits in Controle SHALL NOT be forced; simulation propagation of X is acceptable.
- REQ-019 Output widths SHALL match WIDTH exactly; no sign or zero extension internally.

Reset
- REQ-020 Reset=0 SHALL immediately clear ResultadoReg to 0 and ErroSticky to 0, independent of Clock.
- REQ-021 While Reset=0, registered outputs SHALL stay 0 across clock edges.
- REQ-022 The first rising edge after Reset returns to 1 SHALL load ResultadoReg normally and SHALL set ErroSticky if Controle==11.
- REQ-023 Reset asserted mid-operation SHALL override any pending register update on the same edge.

Structure
- REQ-024 Select encodings (SEL_CH0=00, SEL_CH1=01, SEL_CH2=10, SEL_INV=11) SHALL be constants in the shared package.
- REQ-025 The default WIDTH constant (3) SHALL live in the same shared package.
- REQ-026 The combinational select SHALL be one sub-module mux3_comb (three inputs, Controle, Resultado, Invalido); mux_3x3 wraps it with the register stage.
- REQ-027 No other sub-modules, memories or state machines SHALL be used.

Verification
- REQ-028 Entrada0=111, Entrada1=010, Entrada2=000; Controle stepping 00 -> 01 -> 10 -> 00 one time unit apart -> Resultado 111, 010, 000, 111 in the same timestep.
- REQ-029 Controle=11 with inputs 101/110/011 -> Resultado=000 and Invalido=1; next rising edge -> ErroSticky=1; returning Controle to 00 keeps ErroSticky=1.
- REQ-030 Controle=01 with Entrada1=110, one rising edge -> ResultadoReg=110; change Entrada1 to 001 between edges -> Resultado=001 immediately while ResultadoReg stays 110 until the next edge.
- REQ-031 With ResultadoReg=110 and ErroSticky=1, drive Reset=0 between edges -> both go to 0 at once; they stay 0 over two edges while Reset=0.
- REQ-032 Release Reset with Controle=10 and Entrada2=100 -> ResultadoReg=100 after the first rising edge; ErroSticky stays 0.
